// File: rtl/hpdcache_regbank_be_1r1w_init.sv
// rtl/hpdcache_regbank_be_1r1w_init.sv - 1R1W byte-enable register bank with post-reset init sequencer
// Optional feature macro: HPDCACHE_REGBANK_WR_BYPASS_EN (write-first read on same-address collision).
module hpdcache_regbank_be_1r1w_init #(
  parameter int unsigned           ADDR_SIZE  = 4,
  parameter int unsigned           DATA_SIZE  = 32,
  parameter int unsigned           DEPTH      = 2**ADDR_SIZE,
  parameter logic [DATA_SIZE-1:0]  INIT_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     init_done,
  input  logic                     rd_cs,
  input  logic [ADDR_SIZE-1:0]     rd_addr,
  output logic                     rd_valid,
  output logic [DATA_SIZE-1:0]     rdata,
  input  logic                     wr_cs,
  input  logic [ADDR_SIZE-1:0]     wr_addr,
  input  logic [DATA_SIZE-1:0]     wdata,
  input  logic [DATA_SIZE/8-1:0]   wbe
);

  localparam int unsigned          BE_SIZE = DATA_SIZE/8;
  // One extra bit so DEPTH == 2**ADDR_SIZE is representable in the range compare.
  localparam logic [ADDR_SIZE:0]   LP_DEPTH = (ADDR_SIZE+1)'(DEPTH);
  localparam logic [ADDR_SIZE-1:0] LP_LAST  = ADDR_SIZE'(DEPTH-1);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [ADDR_SIZE-1:0]   r_init_ptr;
  logic [ADDR_SIZE-1:0]   w_init_ptr_next;

  logic [DATA_SIZE-1:0]   r_mem [DEPTH];
  logic                   r_rd_valid;
  logic [DATA_SIZE-1:0]   r_rdata;

  logic                   w_rd_acc;
  logic                   w_wr_acc;
  logic                   w_rd_in_range;
  logic                   w_wr_in_range;
  logic [DATA_SIZE-1:0]   w_rd_stored;
  logic [DATA_SIZE-1:0]   w_rd_word;

  assign init_done     = (r_state == ST_READY);
  assign w_rd_acc      = init_done & rd_cs;
  assign w_wr_acc      = init_done & wr_cs;
  assign w_rd_in_range = ({1'b0, rd_addr} < LP_DEPTH);
  assign w_wr_in_range = ({1'b0, wr_addr} < LP_DEPTH);

  // State register and init pointer; reset restarts the clear sequence from entry 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_INIT;
      r_init_ptr <= '0;
    end else begin
      r_state    <= w_state_next;
      r_init_ptr <= w_init_ptr_next;
    end
  end

  // Next-state logic: walk every entry once, then stay ready until reset.
  always_comb begin
    w_state_next    = r_state;
    w_init_ptr_next = r_init_ptr;
    case (r_state)
      ST_INIT: begin
        if (r_init_ptr == LP_LAST) begin
          w_state_next = ST_READY;
        end else begin
          w_init_ptr_next = r_init_ptr + 1'b1;
        end
      end
      ST_READY: begin
        w_state_next = ST_READY;
      end
      default: begin
        w_state_next = ST_INIT;
      end
    endcase
  end

  // Storage update: init clear has priority; user writes merge enabled bytes, out-of-range dropped.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_mem[r_init_ptr] <= INIT_VALUE;
    end else if (w_wr_acc && w_wr_in_range) begin
      for (int i = 0; i < BE_SIZE; i++) begin
        if (wbe[i]) begin
          r_mem[wr_addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Stored word at the read address; out-of-range reads see zero.
  always_comb begin
    w_rd_stored = '0;
    if (w_rd_in_range) begin
      w_rd_stored = r_mem[rd_addr];
    end
  end

`ifdef HPDCACHE_REGBANK_WR_BYPASS_EN
  // Write-first: enabled bytes of a colliding write are forwarded onto the read path.
  always_comb begin
    w_rd_word = w_rd_stored;
    if (w_wr_acc && w_rd_in_range && (wr_addr == rd_addr)) begin
      for (int i = 0; i < BE_SIZE; i++) begin
        if (wbe[i]) begin
          w_rd_word[8*i +: 8] = wdata[8*i +: 8];
        end
      end
    end
  end
`else
  // Read-first: a colliding read returns the word as stored before the write edge.
  assign w_rd_word = w_rd_stored;
`endif

  // Read output register: valid pulses per accepted read, data holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rdata <= w_rd_word;
      end
    end
  end

  assign rd_valid = r_rd_valid;
  assign rdata    = r_rdata;

endmodule

// File: tb/tb_hpdcache_regbank_be_1r1w_init.sv
// tb/tb_hpdcache_regbank_be_1r1w_init.sv - randomized self-checking bench against a behavioural model
module tb_hpdcache_regbank_be_1r1w_init;

  localparam int          AW     = 4;
  localparam int          DW     = 32;
  localparam int          DEPTH  = 12;
  localparam logic [31:0] INIT_V = 32'h5A5A_0F0F;
`ifdef HPDCACHE_REGBANK_WR_BYPASS_EN
  localparam bit          BYPASS = 1'b1;
`else
  localparam bit          BYPASS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_done;
  logic          rd_cs = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_valid;
  logic [DW-1:0] rdata;
  logic          wr_cs = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [3:0]    wbe = '0;

  always #5 clk = ~clk;

  hpdcache_regbank_be_1r1w_init #(
    .ADDR_SIZE (AW),
    .DATA_SIZE (DW),
    .DEPTH     (DEPTH),
    .INIT_VALUE(INIT_V)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .init_done(init_done),
    .rd_cs    (rd_cs),
    .rd_addr  (rd_addr),
    .rd_valid (rd_valid),
    .rdata    (rdata),
    .wr_cs    (wr_cs),
    .wr_addr  (wr_addr),
    .wdata    (wdata),
    .wbe      (wbe)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] m_mem [16];
  int          m_cycles = 0;
  logic [31:0] m_rdata  = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    rst   = 1'b1;
    rd_cs = 1'b0;
    wr_cs = 1'b0;
    #2;
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_init_done", 32'(init_done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    m_cycles = 0;
    m_rdata  = '0;
    for (int i = 0; i < 16; i++) m_mem[i] = (i < DEPTH) ? INIT_V : 32'd0;
  endtask

  task automatic step(input logic rc, input logic [3:0] ra, input logic wc, input logic [3:0] wa,
                      input logic [31:0] wd, input logic [3:0] be, input string tag);
    logic        ready;
    logic        exp_valid;
    logic [31:0] merged;
    rd_cs   = rc;
    rd_addr = ra;
    wr_cs   = wc;
    wr_addr = wa;
    wdata   = wd;
    wbe     = be;
    ready   = (m_cycles >= DEPTH);
    merged  = m_mem[wa];
    for (int b = 0; b < 4; b++) if (be[b]) merged[8*b +: 8] = wd[8*b +: 8];
    exp_valid = ready && rc;
    if (exp_valid) begin
      if (int'(ra) >= DEPTH)               m_rdata = 32'd0;
      else if (wc && wa == ra && BYPASS)   m_rdata = merged;
      else                                 m_rdata = m_mem[ra];
    end
    if (ready && wc && int'(wa) < DEPTH) m_mem[wa] = merged;
    @(posedge clk);
    #1;
    m_cycles++;
    check_eq({tag, "_valid"}, 32'(rd_valid), 32'(exp_valid));
    check_eq({tag, "_rdata"}, rdata, m_rdata);
    check_eq({tag, "_init_done"}, 32'(init_done), 32'(m_cycles >= DEPTH));
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < 16; a++) step(1'b1, 4'(a), 1'b0, 4'd0, 32'd0, 4'h0, tag);
  endtask

  task automatic random_traffic(input int n);
    for (int k = 0; k < n; k++)
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           32'($urandom), 4'($urandom_range(0, 15)), "rnd");
  endtask

  initial begin
    apply_reset();

    // Requests held high during init must be ignored.
    for (int k = 0; k < DEPTH; k++)
      step(1'b1, 4'($urandom_range(0, 15)), 1'b1, 4'($urandom_range(0, 15)), 32'($urandom), 4'hF, "init");
    read_all("post_init");

    // Byte-enable merge.
    step(1'b0, 4'd0, 1'b1, 4'd3, 32'hAABBCCDD, 4'hF, "be_w1");
    step(1'b0, 4'd0, 1'b1, 4'd3, 32'h11223344, 4'b0101, "be_w2");
    step(1'b1, 4'd3, 1'b0, 4'd0, 32'd0, 4'h0, "be_rd");
    check_eq("be_merge_value", rdata, 32'hAA22CC44);

    // Same-address collision.
    step(1'b0, 4'd0, 1'b1, 4'd5, 32'd0, 4'hF, "col_clr");
    step(1'b1, 4'd5, 1'b1, 4'd5, 32'hFFFFFFFF, 4'hF, "col");
    step(1'b1, 4'd5, 1'b0, 4'd0, 32'd0, 4'h0, "col_after");
    check_eq("col_after_value", rdata, 32'hFFFFFFFF);

    // Back-to-back reads then hold.
    for (int a = 0; a < 4; a++) step(1'b1, 4'(a), 1'b0, 4'd0, 32'd0, 4'h0, "b2b");
    step(1'b0, 4'd7, 1'b0, 4'd0, 32'd0, 4'h0, "hold");
    step(1'b0, 4'd9, 1'b0, 4'd0, 32'd0, 4'h0, "hold");

    // Out of range write dropped, read returns zero.
    step(1'b0, 4'd0, 1'b1, 4'd13, 32'h12345678, 4'hF, "oor_w");
    step(1'b1, 4'd13, 1'b0, 4'd0, 32'd0, 4'h0, "oor_r");
    check_eq("oor_value", rdata, 32'd0);
    read_all("oor_all");

    // No-op write with wbe=0.
    step(1'b0, 4'd0, 1'b1, 4'd2, 32'hCAFEBABE, 4'h0, "nop_w");
    step(1'b1, 4'd2, 1'b0, 4'd0, 32'd0, 4'h0, "nop_r");

    random_traffic(300);
    read_all("rnd_all");

    // Reset mid-traffic: make sure rdata/rd_valid are non-trivial first.
    step(1'b1, 4'd4, 1'b1, 4'd6, 32'h0BADF00D, 4'hF, "pre_rst");
    apply_reset();
    random_traffic(DEPTH);
    read_all("reinit");
    random_traffic(200);
    read_all("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hpdcache_regbank_be_1r1w_init.md
# hpdcache_regbank_be_1r1w_init

Parametrised register-bank memory for hpdcache metadata and data arrays. It replaces the single-port bit-masked bank with:
- independent read and write ports (1R1W)
- byte-enable writes
- a hardware initialisation sequencer that clears every entry after reset
- a registered read-valid flag

It sits under the cache controller wherever small directory, status or MSHR arrays need deterministic contents after reset without a software clear loop.

## Interface
Parameters:
- ADDR_SIZE, default 4, width of the read and write addresses.
- DATA_SIZE, default 32, word width in bits; must be a multiple of 8.
- DEPTH, default 2**ADDR_SIZE, number of entries; 1 ≤ DEPTH ≤ 2**ADDR_SIZE.
- INIT_VALUE, default 0, DATA_SIZE-bit value written to every entry during initialisation.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk  in  1  clock; all state changes on its rising edge.
  - rst  in  1  asynchronous active-high reset.
- init_done  out  1  high once initialisation is complete; requests are accepted only while it is high.
- Read port:
  - rd_cs  in  1  read request.
  - rd_addr  in  ADDR_SIZE  read address.
  - rd_valid  out  1  pulses high the cycle after an accepted read.
  - rdata  out  DATA_SIZE  read data; holds its value between reads.
- Write port:
  - wr_cs  in  1  write request.
  - wr_addr  in  ADDR_SIZE  write address.
  - wdata  in  DATA_SIZE  write data.
  - wbe  in  DATA_SIZE/8  byte enables; bit i covers bits [8i+7:8i].

## Operation
- FSM states: INIT, READY.
- Reset behaviour: rst forces INIT with init_ptr=0, init_done=0, rd_valid=0 and rdata=0.
- INIT:
  - Each cycle, writes INIT_VALUE to mem[init_ptr] and increments init_ptr.
  - When init_ptr==DEPTH-1 has been written, moves to READY and init_done rises.
  - rd_cs and wr_cs are ignored in INIT; rd_valid stays 0.
- READY: stays in READY until rst.
- Accepted read: rd_cs=1 while in READY.
- Accepted write: wr_cs=1 while in READY.
- Write behaviour: for each byte i with wbe[i]=1, mem[wr_addr] byte i takes wdata byte i; bytes with wbe[i]=0 are unchanged. wbe=0 is a legal no-op write.
- Read behaviour: rdata and rd_valid update on the next edge; rdata holds its last value when no read is accepted.
- Out-of-range addresses (addr ≥ DEPTH):
  - Write: dropped; memory unchanged.
  - Read: returns 0 with rd_valid=1.
- Same-address read and write in the same cycle: behaviour is set by the configuration macro (see Configuration).
- Different addresses in the same cycle: both operations proceed independently.
- Reset mid-operation: any in-flight read is discarded (rd_valid=0) and initialisation restarts from entry 0, whatever the previous state.

## Timing
- Initialisation takes exactly DEPTH cycles after rst deasserts; init_done is high on cycle DEPTH+1, counting the first edge with rst low as cycle 1.
- Read latency is 1 cycle from the accepting edge to valid rdata.
- Read throughput is one read per cycle with no bubbles.
- Write takes effect at the accepting edge; a read of the same address on the next cycle returns the new data.
- No backpressure: the only flow control is init_done.

## Configuration
- HPDCACHE_REGBANK_WR_BYPASS_EN defined:
  - A same-cycle, same-address read returns write-first data: bytes with wbe[i]=1 come from wdata, the other bytes from the stored word.
  - The bypass adds one DATA_SIZE-wide mux on the read path.
- HPDCACHE_REGBANK_WR_BYPASS_EN undefined:
  - A same-cycle, same-address read returns the old stored word (read-first).
  - No bypass logic is instantiated.

## Test plan
- Reset and init, with DEPTH=16:
  - Deassert rst, then hold rd_cs=1 and wr_cs=1 throughout → init_done=0 for 16 cycles then 1, rd_valid=0 throughout, no write lands.
  - Then read entries 0..15 → rdata=INIT_VALUE for each.
- Byte-enable merge: write 0xAABBCCDD with wbe=4'hF to address 3, then 0x11223344 with wbe=4'b0101 → a read of address 3 returns 0xAA22CC44 with rd_valid=1 one cycle after rd_cs.
- Same-address collision: with address 5 holding 0x0, read and write (0xFFFFFFFF, wbe=4'hF) address 5 in the same cycle.
  - Without the macro → rdata=0x00000000.
  - With HPDCACHE_REGBANK_WR_BYPASS_EN → rdata=0xFFFFFFFF.
  - In both cases the next read of address 5 → 0xFFFFFFFF.
- Back-to-back reads: rd_cs=1 for 4 cycles on addresses 0,1,2,3 → rd_valid high for 4 consecutive cycles with matching data, and rdata holds the address-3 data afterwards.
- Out of range, with DEPTH=12 and ADDR_SIZE=4: write 0x12345678 to address 13, then read address 13 → rdata=0 and rd_valid=1; entries 0..11 unchanged.
- Reset mid-traffic: assert rst during streaming reads and writes → rd_valid=0 and rdata=0 immediately, init_done=0, and every entry reads INIT_VALUE after re-initialisation.
